// File: rtl/ex_mem_reg_pkg.sv
// Shared CPU definitions for the EX/MEM boundary: widths, branch codes and the bubble control word.
package ex_mem_reg_pkg;

    localparam int unsigned DataWDefault = 16;
    localparam int unsigned RegWDefault  = 4;
    localparam int unsigned CountW       = 16;

    typedef enum logic [2:0] {
        BrEq     = 3'd0,
        BrNe     = 3'd1,
        BrGt     = 3'd2,
        BrLt     = 3'd3,
        BrGe     = 3'd4,
        BrLe     = 3'd5,
        BrOvf    = 3'd6,
        BrUncond = 3'd7
    } branch_op_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic saw_branch;
    } ctrl_t;

    localparam ctrl_t CtrlBubble = '0;

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX-to-MEM pipeline bus: EX-side fields and pipeline controls in, MEM/WB-side fields out.
interface ex_mem_reg_if import ex_mem_reg_pkg::*; #(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned REG_W  = RegWDefault
);
    logic              stall;
    logic              flush;
    logic              exValid;
    logic [DATA_W-1:0] exAluResult;
    logic [DATA_W-1:0] exStoreData;
    logic [REG_W-1:0]  exDstReg;
    logic              exRegWrite;
    logic              exMemToReg;
    logic              exMemRead;
    logic              exMemWrite;
    logic              exSawBranch;
    logic [2:0]        exBranchOp;
    logic              exSetN;
    logic              exSetZ;
    logic              exSetV;
    logic              exN;
    logic              exZ;
    logic              exV;

    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic              memRead;
    logic              memWrite;
    logic              sawBranch;
    logic [2:0]        branchOp;
    logic              N;
    logic              Z;
    logic              V;
    logic [REG_W-1:0]  dstReg;
    logic              regWrite;
    logic              memToReg;
    logic              valid;
    logic [CountW-1:0] instrCount;

    modport master (
        output stall, flush, exValid, exAluResult, exStoreData, exDstReg,
               exRegWrite, exMemToReg, exMemRead, exMemWrite, exSawBranch, exBranchOp,
               exSetN, exSetZ, exSetV, exN, exZ, exV,
        input  address, writeData, memRead, memWrite, sawBranch, branchOp,
               N, Z, V, dstReg, regWrite, memToReg, valid, instrCount
    );

    modport slave (
        input  stall, flush, exValid, exAluResult, exStoreData, exDstReg,
               exRegWrite, exMemToReg, exMemRead, exMemWrite, exSawBranch, exBranchOp,
               exSetN, exSetZ, exSetV, exN, exZ, exV,
        output address, writeData, memRead, memWrite, sawBranch, branchOp,
               N, Z, V, dstReg, regWrite, memToReg, valid, instrCount
    );

endinterface

// File: rtl/ex_mem_reg_flag_reg.sv
// N/Z/V condition-flag register (flag_reg): per-bit load enables, global hold, async reset.
module ex_mem_reg_flag_reg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    input  logic [2:0] en_i,
    input  logic [2:0] d_i,
    output logic [2:0] q_o
);

    logic [2:0] flags_d, flags_q;

    always_comb begin
        flags_d = flags_q;
        if (!hold_i) begin
            flags_d = (en_i & d_i) | (~en_i & flags_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign q_o = flags_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, architectural N/Z/V flags and a retired-instruction
// counter. All outputs come straight from flops.
module ex_mem_reg import ex_mem_reg_pkg::*; #(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned REG_W  = RegWDefault
) (
    input logic         clk,
    input logic         rst,
    ex_mem_reg_if.slave pipe_io
);

    logic              capture;
    ctrl_t             ctrl_d, ctrl_q;
    logic [DATA_W-1:0] address_d, address_q;
    logic [DATA_W-1:0] write_data_d, write_data_q;
    logic [REG_W-1:0]  dst_reg_d, dst_reg_q;
    logic [2:0]        branch_op_d, branch_op_q;
    logic [CountW-1:0] count_d, count_q;
    logic [2:0]        flag_en;
    logic [2:0]        flags_q;

    assign capture = !pipe_io.stall && !pipe_io.flush;

    always_comb begin
        ctrl_d       = ctrl_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        dst_reg_d    = dst_reg_q;
        branch_op_d  = branch_op_q;
        count_d      = count_q;
        if (pipe_io.flush) begin
            ctrl_d       = CtrlBubble;
            address_d    = '0;
            write_data_d = '0;
            dst_reg_d    = '0;
            branch_op_d  = '0;
        end else if (!pipe_io.stall) begin
            // Invalid EX slots still move their data, but their controls collapse to a bubble.
            if (pipe_io.exValid) begin
                ctrl_d = '{valid:      1'b1,
                           reg_write:  pipe_io.exRegWrite,
                           mem_to_reg: pipe_io.exMemToReg,
                           mem_read:   pipe_io.exMemRead,
                           mem_write:  pipe_io.exMemWrite,
                           saw_branch: pipe_io.exSawBranch};
                count_d = count_q + 16'd1;
            end else begin
                ctrl_d = CtrlBubble;
            end
            address_d    = pipe_io.exAluResult;
            write_data_d = pipe_io.exStoreData;
            dst_reg_d    = pipe_io.exDstReg;
            branch_op_d  = pipe_io.exBranchOp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q       <= CtrlBubble;
            address_q    <= '0;
            write_data_q <= '0;
            dst_reg_q    <= '0;
            branch_op_q  <= '0;
            count_q      <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            dst_reg_q    <= dst_reg_d;
            branch_op_q  <= branch_op_d;
            count_q      <= count_d;
        end
    end

    // Branches consume the flags; their set enables must never disturb them.
    assign flag_en = (capture && pipe_io.exValid && !pipe_io.exSawBranch)
                   ? {pipe_io.exSetN, pipe_io.exSetZ, pipe_io.exSetV} : 3'b000;

    ex_mem_reg_flag_reg u_flag_reg (
        .clk_i  (clk),
        .rst_i  (rst),
        .hold_i (!capture),
        .en_i   (flag_en),
        .d_i    ({pipe_io.exN, pipe_io.exZ, pipe_io.exV}),
        .q_o    (flags_q)
    );

    assign pipe_io.address    = address_q;
    assign pipe_io.writeData  = write_data_q;
    assign pipe_io.dstReg     = dst_reg_q;
    assign pipe_io.branchOp   = branch_op_q;
    assign pipe_io.valid      = ctrl_q.valid;
    assign pipe_io.regWrite   = ctrl_q.reg_write;
    assign pipe_io.memToReg   = ctrl_q.mem_to_reg;
    assign pipe_io.memRead    = ctrl_q.mem_read;
    assign pipe_io.memWrite   = ctrl_q.mem_write;
    assign pipe_io.sawBranch  = ctrl_q.saw_branch;
    assign pipe_io.N          = flags_q[2];
    assign pipe_io.Z          = flags_q[1];
    assign pipe_io.V          = flags_q[0];
    assign pipe_io.instrCount = count_q;

endmodule
